pipe_issue_ctrl: RTL and testbench
==================================

// Module: pipe_issue_ctrl
// PURPOSE
// - Issue controller in front of the 4-stage datapath's InstrIn port. Accepts instructions over valid/ready,
//   detects RAW hazards against in-flight writes and inserts NOP bubbles, so no consumer reads a stale register.
// - Also provides run/halt control and a flush (drain) sequence. Sits between the instruction source and top.InstrIn.
// PARAMETERS
// - HAZARD_DEPTH  2   number of previously emitted words checked for RAW (S1->S3->regfile write = 3 edges)
// - STAT_W        16  width of statistics counters (saturating)
// PORTS
// - clk          in   1   clock; all state on rising edge
// - rst          in   1   reset, asynchronous, active-high
// - instr_in     in   32  candidate instruction from source
// - instr_valid  in   1   instr_in is valid
// - instr_ready  out  1   controller accepts instr_in this cycle (fire = valid & ready)
// - run_en       in   1   1: issue allowed; 0: emit NOPs, hold source
// - flush_req    in   1   1-cycle pulse: drain pipeline
// - issue_instr  out  32  registered word driven to datapath InstrIn
// - busy         out  1   FLUSH state active
// - drained      out  1   1-cycle pulse: flush completed
// - stall_cnt    out  STAT_W  cycles a valid instr was held by hazard (ISSUE_STATS_EN only, else 0)
// - issue_cnt    out  STAT_W  real instructions issued (ISSUE_STATS_EN only, else 0)
// BEHAVIOUR
// - Fields: [31:30] zero; [29] DS (1 = IMM operand, RS2 unused); [28:26] ALUOp; [25:21] WS; [20:16] RS1;
//   [15:11] RS2; [15:0] IMM. WE = 1 for any word != 32'h0. NOP = 32'h0000_0000 (WE=0). No register is special.
// - Reset: issue_instr=0 (NOP), history all NOP, state RUN, instr_ready=0 while rst high, busy=0, drained=0, counters=0.
// - History: shift register of the last HAZARD_DEPTH emitted words (incl. NOPs); updated every cycle.
// - hazard = instr_valid & exists h in history with WE(h) & (WS(h)==RS1(in) | (~DS(in) & WS(h)==RS2(in))).
// - States:
//   RUN   : instr_ready = run_en & ~hazard & ~flush_req. On fire, issue_instr<=instr_in next edge; else issue_instr<=NOP.
//           flush_req -> FLUSH (flush wins over a same-cycle fire: ready forced 0, word not accepted).
//   FLUSH : ready=0, busy=1, emit NOP for HAZARD_DEPTH+1 cycles (down-counter); on last, drained pulses 1 cycle
//           with return to RUN. flush_req while in FLUSH restarts the count.
//   run_en low in RUN: NOPs emitted, ready=0; no extra state. run_en has no effect in FLUSH.
// - Latency: fire at edge E -> issue_instr valid after E -> datapath S1 captures at E+1. One word per cycle max.
// - ready depends combinationally on instr_in/instr_valid (allowed); it never depends on ready-of-source.
// - Dependent back-to-back pair: exactly HAZARD_DEPTH NOP bubbles between producer and consumer; distance-2 pair: 1 bubble.
// - Source must hold instr_in stable while valid & ~ready.
// - Async rst mid-FLUSH or mid-stall: everything returns to reset values immediately; pending word is dropped.
// CONFIGURATION
// - `ISSUE_STATS_EN defined: stall_cnt += 1 each cycle in RUN with valid & run_en & hazard; issue_cnt += 1 per fire;
//   both saturate at all-ones; cleared by rst only.
// - Not defined: counter logic omitted, stall_cnt and issue_cnt tied to 0.
// TESTING
// - Reset: rst pulsed mid-cycle -> issue_instr=0, ready=0 immediately; after release, with valid, ready=1 next cycle.
// - Independent stream: 4 words writing r1..r4 from r10/r11 -> issued on 4 consecutive cycles, 0 bubbles.
// - RAW: word A WS=r5, then B RS1=r5 -> A, NOP, NOP, B on issue_instr; B's stall costs 2 cycles (stall_cnt=2 if EN).
// - Immediate op: A WS=r5, B DS=1 with IMM[15:11]=5, RS1=r7 -> no bubble (RS2 ignored).
// - Flush: flush_req coincident with valid -> not accepted; 3 NOPs, drained at 3rd, busy 3 cycles, then accept.
// - Halt: run_en=0 for 5 cycles with valid -> 5 NOPs, ready=0; re-enable -> word issued next edge, issue_cnt+1.

Source files
------------

// File: rtl/pipe_issue_ctrl.sv
// rtl/pipe_issue_ctrl.sv - RAW-hazard issue controller with run/halt and flush; stats counters under `ISSUE_STATS_EN
module pipe_issue_ctrl #(
    parameter int HAZARD_DEPTH = 2,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              run_en,
    input  logic              flush_req,
    output logic [31:0]       issue_instr,
    output logic              busy,
    output logic              drained,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] issue_cnt
);

    localparam int CNT_W = $clog2(HAZARD_DEPTH + 1) + 1;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] w_flush_cnt_nxt;
    logic [31:0]      r_hist [HAZARD_DEPTH];
    logic [31:0]      w_issue_nxt;
    logic             w_hazard;
    logic             w_ready;
    logic             w_fire;
    logic             w_busy;
    logic             w_drained;

    // r_hist[0] is the word currently on issue_instr; older words follow.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < HAZARD_DEPTH; i++) begin
            if ((r_hist[i] != 32'h0) &&
                ((r_hist[i][25:21] == instr_in[20:16]) ||
                 (!instr_in[29] && (r_hist[i][25:21] == instr_in[15:11])))) begin
                w_hazard = 1'b1;
            end
        end
        w_hazard = w_hazard & instr_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_ready         = 1'b0;
        w_busy          = 1'b0;
        w_drained       = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_ready = run_en & ~w_hazard & ~flush_req;
                if (flush_req) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = CNT_W'(HAZARD_DEPTH);
                end
            end
            ST_FLUSH: begin
                w_busy = 1'b1;
                // A new request restarts the drain, so completion is not signalled.
                if (flush_req) begin
                    w_flush_cnt_nxt = CNT_W'(HAZARD_DEPTH);
                end else if (r_flush_cnt == '0) begin
                    w_drained   = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign instr_ready = w_ready & ~rst;
    assign w_fire      = instr_valid & instr_ready;
    assign w_issue_nxt = w_fire ? instr_in : 32'h0;
    assign issue_instr = r_hist[0];
    assign busy        = w_busy;
    assign drained     = w_drained;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HAZARD_DEPTH; i++) begin
                r_hist[i] <= 32'h0;
            end
        end else begin
            r_hist[0] <= w_issue_nxt;
            for (int i = 1; i < HAZARD_DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
        end
    end

`ifdef ISSUE_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_issue_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if ((r_state == ST_RUN) && instr_valid && run_en && w_hazard && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + STAT_W'(1);
            end
            if (w_fire && !(&r_issue_cnt)) begin
                r_issue_cnt <= r_issue_cnt + STAT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign issue_cnt = r_issue_cnt;
`else
    assign stall_cnt = '0;
    assign issue_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb/tb_pipe_issue_ctrl.sv - scoreboard bench for pipe_issue_ctrl with a cycle-level reference model
module tb_pipe_issue_ctrl;

    localparam int HD = 2;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr_in = '0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic          run_en = 1'b1;
    logic          flush_req = 1'b0;
    logic [31:0]   issue_instr;
    logic          busy;
    logic          drained;
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] issue_cnt;

    always #5 clk = ~clk;

    pipe_issue_ctrl #(.HAZARD_DEPTH(HD), .STAT_W(SW)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .run_en(run_en), .flush_req(flush_req),
        .issue_instr(issue_instr), .busy(busy), .drained(drained),
        .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
    );

    typedef struct {
        logic [31:0]   word;
        logic [SW-1:0] stall;
        logic [SW-1:0] issue;
    } iss_t;

    typedef struct {
        logic ready;
        logic busy;
        logic drained;
    } cyc_t;

    iss_t q_iss[$];
    cyc_t q_cyc[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [31:0] m_hist [HD];
    int          m_left;
    int          m_stall;
    int          m_issue;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit raw(input logic [31:0] prod, input logic [31:0] cons);
        return (prod != 32'h0) &&
               ((prod[25:21] == cons[20:16]) || (!cons[29] && (prod[25:21] == cons[15:11])));
    endfunction

    function automatic logic [31:0] mk(input bit ds, input int ws, input int rs1, input int rs2);
        logic [31:0] w;
        w = '0;
        w[29]    = ds;
        w[28:26] = 3'($urandom_range(0, 7));
        w[25:21] = 5'(ws);
        w[20:16] = 5'(rs1);
        w[15:11] = 5'(rs2);
        w[10:0]  = 11'($urandom);
        return w;
    endfunction

    task automatic model_reset();
        foreach (m_hist[i]) m_hist[i] = 32'h0;
        m_left  = 0;
        m_stall = 0;
        m_issue = 0;
    endtask

    task automatic step(input bit v, input logic [31:0] w, input bit re, input bit fl, output bit fired);
        cyc_t        c;
        iss_t        e;
        logic [31:0] emitted;
        bit          haz;
        @(negedge clk);
        instr_valid = v;
        instr_in    = w;
        run_en      = re;
        flush_req   = fl;
        c.busy    = (m_left > 0);
        c.ready   = 1'b0;
        c.drained = 1'b0;
        emitted   = 32'h0;
        fired     = 1'b0;
        if (m_left > 0) begin
            c.drained = (m_left == 1) && !fl;
            m_left    = fl ? HD + 1 : m_left - 1;
        end else begin
            haz = 1'b0;
            if (v) foreach (m_hist[i]) if (raw(m_hist[i], w)) haz = 1'b1;
            c.ready = re && !haz && !fl;
            if (v && re && haz && m_stall < 65535) m_stall++;
            if (v && c.ready) begin
                emitted = w;
                fired   = 1'b1;
                if (m_issue < 65535) m_issue++;
            end
            if (fl) m_left = HD + 1;
        end
        for (int i = HD - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = emitted;
        e.word = emitted;
`ifdef ISSUE_STATS_EN
        e.stall = SW'(m_stall);
        e.issue = SW'(m_issue);
`else
        e.stall = '0;
        e.issue = '0;
`endif
        q_cyc.push_back(c);
        q_iss.push_back(e);
    endtask

    task automatic send(input logic [31:0] w, input int maxc);
        bit f;
        int n;
        n = 0;
        do begin
            step(1'b1, w, 1'b1, 1'b0, f);
            n++;
        end while (!f && n < maxc);
        check("send_accepted", 32'(f), 32'd1);
    endtask

    task automatic idle(input int n);
        bit f;
        repeat (n) step(1'b0, 32'h0, 1'b1, 1'b0, f);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst         = 1'b1;
        instr_valid = 1'b1;
        #1;
        check("rst_issue", issue_instr, 32'h0);
        check("rst_ready", 32'(instr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drained", 32'(drained), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        q_iss.delete();
        q_cyc.delete();
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        instr_valid = 1'b0;
        flush_req   = 1'b0;
        run_en      = 1'b1;
        model_reset();
    endtask

    initial begin
        cyc_t c;
        forever begin
            @(negedge clk);
            #2;
            if (q_cyc.size() > 0) begin
                c = q_cyc.pop_front();
                check("ready", 32'(instr_ready), 32'(c.ready));
                check("busy", 32'(busy), 32'(c.busy));
                check("drained", 32'(drained), 32'(c.drained));
            end
        end
    end

    initial begin
        iss_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_iss.size() > 0) begin
                e = q_iss.pop_front();
                check("issue_instr", issue_instr, e.word);
                check("stall_cnt", 32'(stall_cnt), 32'(e.stall));
                check("issue_cnt", 32'(issue_cnt), 32'(e.issue));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          f;
        bit          have;
        logic [31:0] pw;
        model_reset();
        do_reset();

        for (int i = 1; i <= 4; i++) send(mk(1'b0, i, 10, 11), 1);
        idle(2);
        send(mk(1'b0, 5, 10, 11), 4);
        send(mk(1'b0, 6, 5, 12), 4);
        idle(2);
        send(mk(1'b0, 5, 10, 11), 4);
        send(mk(1'b1, 8, 7, 5), 1);
        idle(2);
        step(1'b1, mk(1'b0, 9, 1, 2), 1'b1, 1'b1, f);
        idle(3);
        send(mk(1'b0, 9, 1, 2), 1);
        repeat (5) step(1'b1, mk(1'b0, 3, 20, 21), 1'b0, 1'b0, f);
        send(mk(1'b0, 3, 20, 21), 1);
        idle(3);

        step(1'b0, 32'h0, 1'b1, 1'b1, f);
        idle(1);
        do_reset();
        send(mk(1'b0, 4, 1, 2), 1);
        step(1'b1, mk(1'b0, 6, 4, 0), 1'b1, 1'b0, f);
        do_reset();
        send(mk(1'b0, 6, 4, 0), 1);

        have = 1'b0;
        pw   = '0;
        repeat (600) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                pw   = ($urandom_range(0, 19) == 0) ? 32'h0 :
                       mk(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                have = 1'b1;
            end
            step(have, have ? pw : 32'h0, $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, f);
            if (f) have = 1'b0;
        end
        idle(6);
        repeat (3) @(negedge clk);
        check("queues_drained", 32'(q_iss.size() + q_cyc.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
